tl45_dprf_scoreboard: RTL and testbench
=======================================

# tl45_dprf_scoreboard

Dual-port register file (DPRF) with an integrated busy scoreboard for the TL45 pipeline. It owns r1..r15 storage and a per-register pending-writer count, and accepts busy-set requests from register-read and result writebacks from two operand forwarding buses. It publishes the busy list and stalls register-read when a destination's pending count would overflow. It sits between the register-read stage and the execute/memory writeback buses.

## Interface
- No parameters; widths fixed: 16 architectural registers (r0 hardwired zero), 32-bit data, 2-bit pending counters.

- i_clk  in  1  core clock
- i_reset  in  1  reset, asynchronous, active-high
- i_pipe_stall  in  1  register-read is stalled; suppresses busy-set
- i_pipe_flush  in  1  pipeline flush; clears all pending counts
- i_read_a1, i_read_a2  in  4  read addresses
- o_read_d1, o_read_d2  out  32  read data (combinational)
- i_setbusy  in  4  destination to mark busy; 0 = none
- o_busy_stall  out  1  setbusy cannot be accepted this cycle
- i_wb1_reg, i_wb2_reg  in  4  writeback destinations; 0 = none
- i_wb1_data, i_wb2_data  in  32  writeback data
- o_busylist  out  15  bit n-1 = register n has pending count != 0

## Operation
- Storage: regs[1..15], 32 bits each; reads of r0 return 0; writes to r0 ignored.
- Per register n: cnt[n] in 0..3; o_busylist[n-1] = (cnt[n] != 0), driven from registered counts.
- Busy-set accepted when i_setbusy != 0, !i_pipe_stall, !i_pipe_flush, !o_busy_stall; adds +1 to cnt[i_setbusy].
- Writeback k (k=1,2) with i_wbk_reg != 0: writes data to regs[i_wbk_reg], subtracts 1 from cnt[i_wbk_reg].
- Per-register net update each cycle: cnt_next = sat(cnt + inc - dec1 - dec2), floor 0, ceiling 3; underflow saturates at 0 and is not an error (late writebacks after flush).
- Same-register dual writeback: wb2 data wins; count decremented by 2 (saturating).
- Setbusy and writeback to same register in one cycle: both applied (net 0 or -1).
- o_busy_stall = (i_setbusy != 0) && cnt[i_setbusy] == 3 && no writeback to i_setbusy this cycle. Combinational; does not depend on i_pipe_stall.
- Flush: all cnt forced to 0 on the next edge; busy-set that cycle is dropped; writebacks that cycle still update storage.
- Reset (async): all regs = 0, all cnt = 0; o_busylist = 0, o_busy_stall = 0 while i_setbusy = 0; reads return 0.

## Timing
- Register writes and count updates take effect at the rising i_clk edge; o_busylist reflects them the following cycle.
- Reads combinational from storage, zero-latency address-to-data.
- Busy-set at edge N -> busylist bit visible after edge N; a writeback to that register at edge N+1 or later clears it (if count was 1).
- Reset assertion mid-operation discards all in-flight counts and data immediately; no edge needed.

## Configuration
- TL45_DPRF_BYPASS_EN defined: read ports forward same-cycle writeback data (wb2 over wb1 over storage) when address matches a nonzero wb reg; register-read sees a result in the cycle it is written.
- Undefined: reads return stored value only; a result is readable one cycle after its writeback edge. Scoreboard behaviour identical in both builds.

## Test plan
- Reset: assert i_reset mid-run with r3 = 0x1234, cnt[3] = 2 -> reads of r3 return 0, o_busylist = 0 immediately.
- Busy/clear: setbusy=5, then wb1_reg=5 data=0xDEADBEEF next cycle -> busylist[4] high one cycle, then low; read r5 = 0xDEADBEEF.
- Saturation: setbusy=7 four consecutive cycles, no wb -> cnt reaches 3, o_busy_stall high on 4th request, busylist[6] stays high; wb2_reg=7 same cycle as 4th request -> stall low, count stays 3.
- Dual writeback: wb1_reg=wb2_reg=9 data 0x1/0x2, cnt[9]=1 -> r9 = 0x2, cnt[9] = 0 (no underflow).
- Flush: cnt[2]=2, cnt[4]=1, flush with setbusy=6 and wb1_reg=2 data 0x55 -> busylist = 0, r2 = 0x55, r6 not busy.
- Bypass: wb1_reg=11 data 0xA5A5A5A5 with read_a1=11 -> o_read_d1 = 0xA5A5A5A5 same cycle when TL45_DPRF_BYPASS_EN defined, old value otherwise.

Source files
------------

// File: rtl/tl45_dprf_scoreboard.sv
// tl45_dprf_scoreboard
// Dual-port register file for r1..r15 with a 2-bit pending-writer count per
// register. Register-read sets registers busy. Two writeback buses store
// results and retire pending writers. r0 is hardwired to zero.
//
// Optional feature (define the macro to enable it):
//   TL45_DPRF_BYPASS_EN - the read ports forward same-cycle writeback data,
//                         with wb2 taking priority over wb1 over storage.
//                         When the macro is undefined, reads return only the
//                         stored value.
module tl45_dprf_scoreboard (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [3:0]  i_read_a1,
  input  logic [3:0]  i_read_a2,
  output logic [31:0] o_read_d1,
  output logic [31:0] o_read_d2,
  input  logic [3:0]  i_setbusy,
  output logic        o_busy_stall,
  input  logic [3:0]  i_wb1_reg,
  input  logic [3:0]  i_wb2_reg,
  input  logic [31:0] i_wb1_data,
  input  logic [31:0] i_wb2_data,
  output logic [14:0] o_busylist
);

  logic [31:0] regs     [1:15];
  logic [1:0]  cnt      [1:15];
  logic [1:0]  cnt_next [1:15];

  // Zero-based views, so that address 0 indexes a constant zero entry.
  logic [31:0] rf_view  [16];
  logic [1:0]  cnt_view [16];
  logic        setbusy_accept;

  // Build the zero-based views of storage and counts.
  always_comb begin
    rf_view[0]  = '0;
    cnt_view[0] = '0;
    for (int n = 1; n < 16; n++) begin
      rf_view[n]  = regs[n];
      cnt_view[n] = cnt[n];
    end
  end

  // Stall a busy-set whose target is saturated and is not retiring a writer this cycle.
  always_comb begin
    o_busy_stall = (i_setbusy != 4'd0) && (cnt_view[i_setbusy] == 2'd3) &&
                   (i_wb1_reg != i_setbusy) && (i_wb2_reg != i_setbusy);
    setbusy_accept = (i_setbusy != 4'd0) && !i_pipe_stall && !i_pipe_flush &&
                     !o_busy_stall;
  end

  // Compute the net saturating count update for each register.
  always_comb begin
    logic [2:0] up;
    logic [2:0] down;
    logic [2:0] diff;
    for (int n = 1; n < 16; n++) begin
      up   = {1'b0, cnt[n]} + {2'b00, (setbusy_accept && (i_setbusy == 4'(n)))};
      down = {2'b00, (i_wb1_reg == 4'(n))} + {2'b00, (i_wb2_reg == 4'(n))};
      diff = up - down;
      if (i_pipe_flush || (down >= up)) begin
        cnt_next[n] = 2'd0;
      end else if (diff > 3'd3) begin
        cnt_next[n] = 2'd3;
      end else begin
        cnt_next[n] = diff[1:0];
      end
    end
  end

  // Register the pending counts.
  // NOTE: Sequential state uses non-blocking assignments only, so every flop
  //       samples its value from before the clock edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int n = 1; n < 16; n++) cnt[n] <= 2'd0;
    end else begin
      for (int n = 1; n < 16; n++) cnt[n] <= cnt_next[n];
    end
  end

  // Write writeback results to storage. wb2 wins when both target one register.
  // NOTE: This storage is reset because reads must return 0 immediately after
  //       reset. For that reason it is built from flops, not an inferred RAM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int n = 1; n < 16; n++) regs[n] <= '0;
    end else begin
      for (int n = 1; n < 16; n++) begin
        if (i_wb2_reg == 4'(n)) begin
          regs[n] <= i_wb2_data;
        end else if (i_wb1_reg == 4'(n)) begin
          regs[n] <= i_wb1_data;
        end
      end
    end
  end

  // Drive the combinational read ports, with optional same-cycle forwarding.
  always_comb begin
    o_read_d1 = rf_view[i_read_a1];
    o_read_d2 = rf_view[i_read_a2];
`ifdef TL45_DPRF_BYPASS_EN
    if (i_read_a1 != 4'd0) begin
      if (i_wb2_reg == i_read_a1) begin
        o_read_d1 = i_wb2_data;
      end else if (i_wb1_reg == i_read_a1) begin
        o_read_d1 = i_wb1_data;
      end
    end
    if (i_read_a2 != 4'd0) begin
      if (i_wb2_reg == i_read_a2) begin
        o_read_d2 = i_wb2_data;
      end else if (i_wb1_reg == i_read_a2) begin
        o_read_d2 = i_wb1_data;
      end
    end
`endif
  end

  // Publish the busy list from the registered counts.
  always_comb begin
    for (int n = 1; n < 16; n++) o_busylist[n-1] = (cnt[n] != 2'd0);
  end

endmodule

// File: tb/tb_tl45_dprf_scoreboard.sv
// tb_tl45_dprf_scoreboard
// Directed bench for tl45_dprf_scoreboard. Expected values are pushed to a
// scoreboard queue when stimulus is driven, and popped and compared when the
// corresponding output is sampled at the falling edge.
module tb_tl45_dprf_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_pipe_stall = 1'b0;
  logic        i_pipe_flush = 1'b0;
  logic [3:0]  i_read_a1 = '0;
  logic [3:0]  i_read_a2 = '0;
  logic [31:0] o_read_d1;
  logic [31:0] o_read_d2;
  logic [3:0]  i_setbusy = '0;
  logic        o_busy_stall;
  logic [3:0]  i_wb1_reg = '0;
  logic [3:0]  i_wb2_reg = '0;
  logic [31:0] i_wb1_data = '0;
  logic [31:0] i_wb2_data = '0;
  logic [14:0] o_busylist;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int total = 0;
  int bad   = 0;

  tl45_dprf_scoreboard dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pipe_stall (i_pipe_stall),
    .i_pipe_flush (i_pipe_flush),
    .i_read_a1    (i_read_a1),
    .i_read_a2    (i_read_a2),
    .o_read_d1    (o_read_d1),
    .o_read_d2    (o_read_d2),
    .i_setbusy    (i_setbusy),
    .o_busy_stall (o_busy_stall),
    .i_wb1_reg    (i_wb1_reg),
    .i_wb2_reg    (i_wb2_reg),
    .i_wb1_data   (i_wb1_data),
    .i_wb2_data   (i_wb2_data),
    .o_busylist   (o_busylist)
  );

  always #5 i_clk = ~i_clk;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  // Pop the oldest expectation from the queue and compare the observed value with it.
  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_pipe_stall = 1'b0;
    i_pipe_flush = 1'b0;
    i_setbusy    = '0;
    i_wb1_reg    = '0;
    i_wb2_reg    = '0;
    i_wb1_data   = '0;
    i_wb2_data   = '0;
  endtask

  initial begin
    // Reset state
    #2 i_reset = 1'b1;
    i_read_a1 = 4'd5;
    i_read_a2 = 4'd0;
    repeat (2) @(posedge i_clk);
    push("rst_busylist", 32'h0);
    push("rst_stall", 32'h0);
    push("rst_read_r5", 32'h0);
    push("rst_read_r0", 32'h0);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    check({31'h0, o_busy_stall});
    check(o_read_d1);
    check(o_read_d2);
    i_reset = 1'b0;
    step();

    // Busy-set on r5, then clear it with a writeback
    i_setbusy = 4'd5;
    push("bl_before_set5", 32'h0);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    step();
    idle();
    i_wb1_reg  = 4'd5;
    i_wb1_data = 32'hDEADBEEF;
    push("bl_set5", 32'h0010);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    step();
    idle();
    i_read_a1 = 4'd5;
    push("bl_clr5", 32'h0);
    push("rd_r5", 32'hDEADBEEF);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    check(o_read_d1);

    // Saturate r7: requests 1 to 3 are accepted, request 4 stalls
    for (int i = 0; i < 3; i++) begin
      step();
      i_setbusy = 4'd7;
      push("stall_fill7", 32'h0);
      @(negedge i_clk);
      check({31'h0, o_busy_stall});
    end
    step();
    i_setbusy = 4'd7;
    push("stall_full7", 32'h1);
    @(negedge i_clk);
    check({31'h0, o_busy_stall});
    i_wb2_reg  = 4'd7;
    i_wb2_data = 32'h77;
    #1;
    push("stall_full7_wb", 32'h0);
    check({31'h0, o_busy_stall});
    step();
    idle();
    push("bl_sat7", 32'h0040);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    // r7 still holds a count of 3, so three writebacks are needed to clear it
    for (int i = 0; i < 3; i++) begin
      i_wb1_reg  = 4'd7;
      i_wb1_data = 32'h70 + 32'(i);
      step();
      idle();
      push("bl_drain7", (i < 2) ? 32'h0040 : 32'h0);
      @(negedge i_clk);
      check({17'h0, o_busylist});
    end

    // A pipeline stall suppresses busy-set
    step();
    i_setbusy    = 4'd8;
    i_pipe_stall = 1'b1;
    step();
    idle();
    push("bl_pipe_stall", 32'h0);
    @(negedge i_clk);
    check({17'h0, o_busylist});

    // Dual writeback to r9: wb2 data wins and the count does not underflow
    step();
    i_setbusy = 4'd9;
    step();
    idle();
    i_wb1_reg  = 4'd9;
    i_wb1_data = 32'h1;
    i_wb2_reg  = 4'd9;
    i_wb2_data = 32'h2;
    step();
    idle();
    i_read_a2 = 4'd9;
    push("bl_dual9", 32'h0);
    push("rd_r9", 32'h2);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    check(o_read_d2);
    step();
    i_setbusy = 4'd9;
    step();
    idle();
    push("bl_reset9", 32'h0100);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    i_wb1_reg = 4'd9;
    step();
    idle();

    // Flush while r2 and r4 are pending
    i_setbusy = 4'd2;
    step();
    step();
    i_setbusy = 4'd4;
    step();
    idle();
    push("bl_pre_flush", 32'h000A);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    i_pipe_flush = 1'b1;
    i_setbusy    = 4'd6;
    i_wb1_reg    = 4'd2;
    i_wb1_data   = 32'h55;
    step();
    idle();
    i_read_a1 = 4'd2;
    push("bl_flush", 32'h0);
    push("rd_r2", 32'h55);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    check(o_read_d1);
    i_wb1_reg  = 4'd2;
    i_wb1_data = 32'h56;
    step();
    idle();
    push("bl_late_wb", 32'h0);
    @(negedge i_clk);
    check({17'h0, o_busylist});

    // Reset asserted mid-run while r3 holds 0x1234 with a count of 2
    step();
    i_wb1_reg  = 4'd3;
    i_wb1_data = 32'h1234;
    step();
    idle();
    i_setbusy = 4'd3;
    step();
    step();
    idle();
    i_read_a1 = 4'd3;
    push("bl_r3_busy", 32'h0004);
    push("rd_r3", 32'h1234);
    @(negedge i_clk);
    check({17'h0, o_busylist});
    check(o_read_d1);
    i_reset = 1'b1;
    #1;
    push("bl_async_rst", 32'h0);
    push("rd_r3_async_rst", 32'h0);
    check({17'h0, o_busylist});
    check(o_read_d1);
    #1 i_reset = 1'b0;
    step();

    // Same-cycle read of a register that is being written back
    i_wb1_reg  = 4'd11;
    i_wb1_data = 32'h1111;
    step();
    idle();
    i_wb1_reg  = 4'd11;
    i_wb1_data = 32'hA5A5A5A5;
    i_read_a1  = 4'd11;
`ifdef TL45_DPRF_BYPASS_EN
    push("rd_bypass11", 32'hA5A5A5A5);
`else
    push("rd_bypass11", 32'h1111);
`endif
    @(negedge i_clk);
    check(o_read_d1);
    step();
    idle();
    push("rd_r11_after", 32'hA5A5A5A5);
    @(negedge i_clk);
    check(o_read_d1);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
